// File: rtl/mem_if_pkg.sv
// Shared definitions for the MAR/MDR memory interface: FSM encoding,
// RW polarity and default bus widths used by the controller, registers and responder.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wait-state count saturates at the 4-bit counter maximum.
  function automatic logic [3:0] wait_init(input int cycles);
    logic [3:0] res;
    if (cycles > 15) begin
      res = 4'd15;
    end else if (cycles < 0) begin
      res = 4'd0;
    end else begin
      res = 4'(cycles);
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed RAM with a synchronous write port and a registered read port.
// Stored contents are never reset; only the read register clears.
module mem_array
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts Enable/RW requests, inserts WAIT_CYCLES wait
// states, performs one RAM access and answers with a four-phase MFC handshake.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              MFC,
  output logic              Busy
);

  localparam logic [3:0] WAIT_INIT = wait_init(WAIT_CYCLES);

  mem_state_e        state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              load_s;
  logic              rw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              mfc_r;
  logic              busy_r;
  logic              wr_en_s;
  logic              rd_en_s;

  // Next-state and wait counter; ACCESS ignores Enable so a started access always completes.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (Enable) begin
          state_s = WAIT;
          cnt_s   = WAIT_INIT;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!Enable) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_s = ACCESS;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ACCESS: begin
        state_s = DONE;
      end
      DONE: begin
        if (!Enable) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      mfc_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mfc_r   <= (state_s == DONE);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Request capture at acceptance; later input changes do not disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_r   <= RW_READ;
      addr_r <= {ADDR_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      rw_r   <= RW;
      addr_r <= Addr;
      data_r <= DataIn;
    end else begin
      rw_r   <= rw_r;
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  assign wr_en_s = (state_r == ACCESS) && (rw_r == RW_WRITE) && !reset;
  assign rd_en_s = (state_r == ACCESS) && (rw_r == RW_READ) && !reset;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .rd_en   (rd_en_s),
    .addr    (addr_r),
    .wr_data (data_r),
    .rd_data (DataOut)
  );

  assign MFC  = mfc_r;
  assign Busy = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) driven by
// directed and random four-phase transactions against a plain-array memory model.
module tb_mem_responder;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       en, rw, mfc, busy;
  logic [1:0][7:0]  addr;
  logic [1:0][15:0] din, dout;

  int vectors = 0;
  int miscompares = 0;
  int wc [2] = '{2, 0};

  logic [15:0] model_mem [2][256];
  bit          written   [2][256];
  logic [15:0] last_rd   [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .Enable(en[0]), .RW(rw[0]), .Addr(addr[0]),
    .DataIn(din[0]), .DataOut(dout[0]), .MFC(mfc[0]), .Busy(busy[0]));

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .Enable(en[1]), .RW(rw[1]), .Addr(addr[1]),
    .DataIn(din[1]), .DataOut(dout[1]), .MFC(mfc[1]), .Busy(busy[1]));

  // One complete four-phase transaction on responder s, checked against the model.
  task automatic access(input int s, input logic r, input logic [7:0] a,
                        input logic [15:0] d, input int hold, input bit scramble);
    int n;
    logic [15:0] exp;
    @(negedge clk);
    en[s] = 1'b1; rw[s] = r; addr[s] = a; din[s] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && n == 1) begin
        addr[s] = ~a; din[s] = ~d; rw[s] = ~r;
      end
    end while (!mfc[s] && n < 40);
    vectors++;
    if (n - 1 != wc[s] + 2 || !mfc[s]) begin
      miscompares++;
      $display("FAIL latency dut%0d: got %0d cycles (mfc=%b), expected %0d", s, n - 1, mfc[s], wc[s] + 2);
    end
    if (r) begin
      exp = model_mem[s][a];
      last_rd[s] = exp;
    end else begin
      model_mem[s][a] = d;
      written[s][a] = 1'b1;
      exp = last_rd[s];
    end
    vectors++;
    if (dout[s] !== exp) begin
      miscompares++;
      $display("FAIL dataout dut%0d rw=%b addr=%h: got %h expected %h", s, r, a, dout[s], exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      vectors++;
      if (mfc[s] !== 1'b1 || busy[s] !== 1'b1 || dout[s] !== exp) begin
        miscompares++;
        $display("FAIL hold dut%0d: mfc=%b busy=%b dout=%h expected 1 1 %h", s, mfc[s], busy[s], dout[s], exp);
      end
    end
    en[s] = 1'b0;
    @(negedge clk);
    vectors++;
    if (mfc[s] !== 1'b0 || busy[s] !== 1'b0 || dout[s] !== exp) begin
      miscompares++;
      $display("FAIL release dut%0d: mfc=%b busy=%b dout=%h expected 0 0 %h", s, mfc[s], busy[s], dout[s], exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 2'b11; rw = 2'b00; addr = '0; din = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (mfc !== 2'b00 || busy !== 2'b00 || dout !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_hold: mfc=%b busy=%b dout=%h expected 0 0 0", mfc, busy, dout);
      end
    end
    reset = 1'b0; en = 2'b00;
    @(negedge clk);
    vectors++;
    if (mfc !== 2'b00 || busy !== 2'b00 || dout !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release: mfc=%b busy=%b dout=%h expected 0 0 0", mfc, busy, dout);
    end
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
  endtask

  task automatic test_write_read();
    access(0, 1'b0, 8'h3C, 16'hBEEF, 0, 1'b0);
    access(0, 1'b1, 8'h3C, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_zero_wait();
    access(1, 1'b0, 8'h00, 16'h1234, 0, 1'b0);
    access(1, 1'b1, 8'h00, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_abort();
    access(0, 1'b0, 8'h10, 16'h5555, 0, 1'b0);
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h10; din[0] = 16'hAAAA;
    @(negedge clk);
    en[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (mfc[0] !== 1'b0 || busy[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort cycle %0d: mfc=%b busy=%b expected 0 0", i, mfc[0], busy[0]);
      end
    end
    access(0, 1'b1, 8'h10, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_handshake_hold();
    access(0, 1'b1, 8'h3C, 16'h0000, 5, 1'b0);
    access(0, 1'b0, 8'h3D, 16'h7E57, 0, 1'b0);
  endtask

  task automatic test_input_sampling();
    access(0, 1'b0, 8'hDF, 16'h0F0F, 0, 1'b0);
    access(0, 1'b0, 8'h20, 16'hC0DE, 0, 1'b1);
    access(0, 1'b1, 8'h20, 16'h0000, 0, 1'b0);
    access(0, 1'b1, 8'hDF, 16'h0000, 0, 1'b0);
    access(1, 1'b1, 8'h00, 16'h0000, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h3C; din[0] = 16'hDEAD;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; en[0] = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    vectors++;
    if (mfc !== 2'b00 || busy !== 2'b00 || dout !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: mfc=%b busy=%b dout=%h expected 0 0 0", mfc, busy, dout);
    end
    access(0, 1'b1, 8'h3C, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_random();
    int s;
    logic r;
    logic [7:0] a;
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      if (r && !written[s][a]) r = 1'b0;
      access(s, r, a, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_abort();
    test_handshake_hold();
    test_input_sampling();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
